// File: rtl/fpu_mul_if.sv
// fpu_mul_if: operand/result bundle for the binary32 multiplier.
//   En     : capture enable, driven by issue logic
//   Rs1/2  : binary32 operands
//   Result : registered binary32 product
//   Flags  : {NV,DZ,OF,UF,NX}, present only with FPU_MUL_FLAGS_EN
// master = issue side, slave = multiplier.
interface fpu_mul_if #(parameter int FLEN = 32);
  logic            En;
  logic [FLEN-1:0] Rs1;
  logic [FLEN-1:0] Rs2;
  logic [FLEN-1:0] Result;
`ifdef FPU_MUL_FLAGS_EN
  logic [4:0]      Flags;
  modport master (output En, Rs1, Rs2, input  Result, Flags);
  modport slave  (input  En, Rs1, Rs2, output Result, Flags);
`else
  modport master (output En, Rs1, Rs2, input  Result);
  modport slave  (input  En, Rs1, Rs2, output Result);
`endif
endinterface

// File: rtl/fpu_mul.sv
// fpu_mul: binary32 multiplier, round-to-nearest-even, FTZ on inputs and
// outputs, one registered stage.
//   CLK   : rising-edge clock
//   rst_n : async active-low reset, clears Result (and Flags)
//   bus   : fpu_mul_if.slave (En, Rs1, Rs2 in; Result, Flags out)
// Optional macro FPU_MUL_FLAGS_EN adds the registered {NV,DZ,OF,UF,NX} flags.
module fpu_mul #(
  parameter int FLEN = 32
) (
  input  logic     CLK,
  input  logic     rst_n,
  fpu_mul_if.slave bus
);

  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [22:0] man;
    logic        zero;  // true zero or subnormal (flushed)
    logic        inf;
    logic        nan;
  } op_t;

  function automatic op_t dec(input logic [31:0] x);
    op_t o;
    o.sgn  = x[31];
    o.exp  = x[30:23];
    o.man  = x[22:0];
    o.zero = (x[30:23] == 8'd0);
    o.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    o.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    return o;
  endfunction

  op_t                a, b;
  logic               sgn, inv, g, r, st, rup, of, uf;
  logic [47:0]        prod;
  logic signed [9:0]  exp_raw, exp_n, exp_f;
  logic [22:0]        frac, frac_f;
  logic [24:0]        mant_r;
  logic [FLEN-1:0]    res_d, res_q;

  always_comb begin
    a       = dec(bus.Rs1);
    b       = dec(bus.Rs2);
    sgn     = a.sgn ^ b.sgn;
    inv     = (a.inf & b.zero) | (b.inf & a.zero);
    prod    = {24'd0, 1'b1, a.man} * {24'd0, 1'b1, b.man};
    exp_raw = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'sd127;
    // product lies in [1,4): bit 47 set means a one-place normalising shift
    if (prod[47]) begin
      frac  = prod[46:24];
      g     = prod[23];
      r     = prod[22];
      st    = |prod[21:0];
      exp_n = exp_raw + 10'sd1;
    end else begin
      frac  = prod[45:23];
      g     = prod[22];
      r     = prod[21];
      st    = |prod[20:0];
      exp_n = exp_raw;
    end
    rup    = g & (r | st | frac[0]);
    mant_r = {1'b0, 1'b1, frac} + {24'd0, rup};
    // rounding carry-out: mantissa becomes 1.000..., bump exponent
    if (mant_r[24]) begin
      exp_f  = exp_n + 10'sd1;
      frac_f = mant_r[23:1];
    end else begin
      exp_f  = exp_n;
      frac_f = mant_r[22:0];
    end
    of = (exp_f >= 10'sd255);
    uf = (exp_f <= 10'sd0);
  end

  always_comb begin
    res_d = {sgn, exp_f[7:0], frac_f};
    if (a.nan | b.nan | inv)  res_d = 32'h7FC0_0000;
    else if (a.inf | b.inf)   res_d = {sgn, 8'hFF, 23'd0};
    else if (a.zero | b.zero) res_d = {sgn, 31'd0};
    else if (of)              res_d = {sgn, 8'hFF, 23'd0};
    else if (uf)              res_d = {sgn, 31'd0};
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)      res_q <= '0;
    else if (bus.En) res_q <= res_d;
  end

  assign bus.Result = res_q;

`ifdef FPU_MUL_FLAGS_EN
  logic       snan;
  logic [4:0] flg_d, flg_q;

  always_comb begin
    // signalling NaN: all-ones exponent, nonzero mantissa, quiet bit clear
    snan  = ((bus.Rs1[30:22] == 9'h1FE) && (bus.Rs1[21:0] != 22'd0)) |
            ((bus.Rs2[30:22] == 9'h1FE) && (bus.Rs2[21:0] != 22'd0));
    flg_d = {1'b0, 1'b0, of, uf, of | uf | g | r | st};
    if (a.nan | b.nan | inv)                      flg_d = {snan | inv, 4'b0000};
    else if (a.inf | b.inf | a.zero | b.zero)     flg_d = 5'b00000;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)      flg_q <= '0;
    else if (bus.En) flg_q <= flg_d;
  end

  assign bus.Flags = flg_q;
`endif

endmodule

// File: tb/tb_fpu_mul.sv
module tb_fpu_mul;
  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  fpu_mul_if #(.FLEN(32)) bus();
  fpu_mul #(.FLEN(32)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

  int cmp = 0;
  int bad = 0;
  logic [31:0] exp_res;
  logic [4:0]  exp_flg;

  // Reference: exact integer product, normalise to a 24-bit integer
  // significand, round by comparing the discarded remainder with one half.
  function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    bit az, bz, ai, bi, an, bn, nv, s, nx;
    longint unsigned p, q, rem, half;
    int e, sh, be;
    az = (a[30:23] == 0);
    bz = (b[30:23] == 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    nv = (an && !a[22]) || (bn && !b[22]) || (ai && bz) || (bi && az);
    if (an || bn)                 return {nv, 4'b0, 32'h7FC00000};
    if ((ai && bz) || (bi && az)) return {5'b10000, 32'h7FC00000};
    if (ai || bi)                 return {5'b0, s, 8'hFF, 23'd0};
    if (az || bz)                 return {5'b0, s, 31'd0};
    p  = (longint'(a[22:0]) + 64'd8388608) * (longint'(b[22:0]) + 64'd8388608);
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = 0;
    while ((p >> sh) >= 64'd16777216) sh++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == 64'd16777216) begin q = q >> 1; sh++; end
    be = e + sh - 23;
    if (be >= 255) return {5'b00101, s, 8'hFF, 23'd0};
    if (be <= 0)   return {5'b00011, s, 31'd0};
    return {4'b0000, nx, s, be[7:0], q[22:0]};
  endfunction

  task automatic check(input string tag);
    cmp++;
    assert (bus.Result === exp_res) else begin
      bad++;
      $error("FAIL %s Result got %h want %h", tag, bus.Result, exp_res);
    end
`ifdef FPU_MUL_FLAGS_EN
    cmp++;
    assert (bus.Flags === exp_flg) else begin
      bad++;
      $error("FAIL %s Flags got %b want %b", tag, bus.Flags, exp_flg);
    end
`endif
  endtask

  // Apply operands for one edge, update model if enabled, check after the edge.
  task automatic step(input logic en, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge CLK);
    bus.En = en; bus.Rs1 = a; bus.Rs2 = b;
    if (en) {exp_flg, exp_res} = ref_mul(a, b);
    @(posedge CLK);
    #1;
    check(tag);
  endtask

  task automatic lit(input logic [31:0] want, input string tag);
    cmp++;
    assert (bus.Result === want) else begin
      bad++;
      $error("FAIL %s Result got %h want %h", tag, bus.Result, want);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 11))
      0:  x[30:23] = 8'd0;                                   // zero / subnormal
      1:  begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end       // infinity
      2:  begin x[30:23] = 8'hFF; if (x[22:0] == 0) x[0] = 1'b1; end // NaN
      3:  x[30:23] = 8'($urandom_range(1, 45));              // underflow region
      4:  x[30:23] = 8'($urandom_range(200, 254));           // overflow region
      5:  begin x[30:23] = 8'($urandom_range(100, 150)); x[15:0] = 16'd0; end // ties
      6:  begin x[30:23] = 8'($urandom_range(100, 150)); x[22:4] = '1; end    // carry-out
      default: x[30:23] = 8'($urandom_range(60, 190));
    endcase
    return x;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; bus.En = 1'b0; bus.Rs1 = '0; bus.Rs2 = '0;
    exp_res = '0; exp_flg = '0;
    #12;
    check("reset");
    @(negedge CLK); rst_n = 1'b1;

    step(1, 32'h41440000, 32'h40400000, "12.25x3");    lit(32'h42130000, "12.25x3_lit");
    step(1, 32'h41440000, 32'h3E800000, "12.25x0.25"); lit(32'h40440000, "12.25x0.25_lit");
    step(1, 32'hC0000000, 32'h40400000, "neg_pos");    lit(32'hC0C00000, "neg_pos_lit");
    step(1, 32'hC0000000, 32'hC0400000, "neg_neg");    lit(32'h40C00000, "neg_neg_lit");
    step(1, 32'h00000000, 32'h3E800000, "zero");       lit(32'h00000000, "zero_lit");
    step(1, 32'h80000000, 32'h3F800000, "negzero");    lit(32'h80000000, "negzero_lit");
    step(1, 32'h3F800001, 32'h3F800001, "round");      lit(32'h3F800002, "round_lit");
    step(1, 32'h7F800000, 32'h00000000, "inf_x_0");    lit(32'h7FC00000, "inf_x_0_lit");
    step(1, 32'h71800000, 32'h71800000, "overflow");   lit(32'h7F800000, "overflow_lit");
    step(1, 32'h0DA24260, 32'h0DA24260, "underflow");  lit(32'h00000000, "underflow_lit");
    step(1, 32'h3F800000, 32'h00400000, "subnorm_in"); lit(32'h00000000, "subnorm_in_lit");
    step(1, 32'h3FC00000, 32'h3FC00000, "pre_hold");
    step(0, 32'h40000000, 32'h40000000, "hold");       lit(32'h40100000, "hold_lit");

    // async reset between edges
    @(negedge CLK); #2; rst_n = 1'b0; #1;
    exp_res = '0; exp_flg = '0;
    check("async_reset");
    // release with valid operands already applied
    bus.En = 1'b1; bus.Rs1 = 32'h40400000; bus.Rs2 = 32'h40800000;
    #1; rst_n = 1'b1;
    {exp_flg, exp_res} = ref_mul(32'h40400000, 32'h40800000);
    @(posedge CLK); #1;
    check("post_reset"); lit(32'h41400000, "post_reset_lit");

    for (int i = 0; i < 600; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      step(($urandom_range(0, 3) != 0), ra, rb, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout Result got %h want completion", bus.Result);
    $fatal(1, "timeout");
  end
endmodule
